// File: rtl/mha_result_collector.sv
// Two-bank output buffer behind the systolic matmul: captures finished result blocks one
// row per bank and streams full banks out over valid/ready while the other bank fills.
module mha_result_collector #(
    parameter int DATA_WIDTH = 256,
    parameter int COL_Y      = 2,
    parameter int ROW_TOTAL  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_stall,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  overflow,
    output logic                  done
);

    localparam int IDX_W = $clog2(COL_Y);
    localparam int CNT_W = $clog2(ROW_TOTAL + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COL_Y - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROW_TOTAL - 1);

    logic                  wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic [CNT_W-1:0]      row_cnt_q, row_cnt_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] mem_q [2][COL_Y];

    logic                  wr_fire;
    logic                  wr_drop;
    logic                  rd_fire;
    logic                  rd_at_last;

    // Outputs depend only on registers, so upstream and consumer see no combinational loop.
    assign in_stall   = bank_full_q[wr_bank_q];
    assign rd_at_last = (rd_idx_q == LAST_IDX);
    assign out_valid  = bank_full_q[rd_bank_q] & ~done_q;
    assign out_last   = out_valid & rd_at_last;
    assign out_data   = out_valid ? mem_q[rd_bank_q][rd_idx_q] : '0;
    assign overflow   = overflow_q;
    assign done       = done_q;

    // A strobe into a full bank is lost even if that bank drains this same cycle (no bypass).
    assign wr_fire = in_valid & ~done_q & ~bank_full_q[wr_bank_q];
    assign wr_drop = in_valid & ~done_q &  bank_full_q[wr_bank_q];
    assign rd_fire = out_valid & out_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        bank_full_d = bank_full_q;
        row_cnt_d   = row_cnt_q;
        overflow_d  = overflow_q | wr_drop;
        done_d      = done_q;

        // The bank being completed is empty and the bank being freed is full, so the two
        // updates below never target the same bit of bank_full.
        if (wr_fire) begin
            if (wr_idx_q == LAST_IDX) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_idx_d               = '0;
                wr_bank_d              = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end

        if (rd_fire) begin
            if (rd_at_last) begin
                bank_full_d[rd_bank_q] = 1'b0;
                rd_idx_d               = '0;
                rd_bank_d              = ~rd_bank_q;
                row_cnt_d              = row_cnt_q + 1'b1;
                if (row_cnt_q == LAST_ROW) begin
                    done_d = 1'b1;
                end
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values of its peers, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            bank_full_q <= 2'b00;
            row_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            bank_full_q <= bank_full_d;
            row_cnt_q   <= row_cnt_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    // NOTE: the buffer RAM has no reset; bank_full guards every read, so stale words are
    // never visible and the array can map onto plain storage.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_idx_q] <= in_data;
        end
    end

endmodule
